// File: rtl/life_controller.sv
// rtl/life_controller.sv - Game of Life sequencing controller
// Debounces the board buttons and drives the datapath mode, program and commit strobes.
module life_controller #(
  parameter int NUM_CELLS       = 49,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int GEN_PERIOD      = 25000000,
  parameter int CW              = $clog2(NUM_CELLS + 1)
) (
  input  logic          clka,
  input  logic          rst,
  input  logic          btn0_raw,
  input  logic          btn1_raw,
  input  logic          btn_start_raw,
  input  logic          btn_pause_raw,
  input  logic          btn_clear_raw,
  output logic [1:0]    state,
  output logic          prog0,
  output logic          prog1,
  output logic          commit,
  output logic          stop,
  output logic [CW-1:0] cell_cnt,
  output logic [15:0]   gen_count,
  output logic          paused
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(GEN_PERIOD + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST    = TW'(GEN_PERIOD - 1);
  localparam logic [CW-1:0] CELLS_MAX = CW'(NUM_CELLS);

  typedef enum logic [2:0] {
    S_IDLE, S_PROG, S_WAIT, S_EVAL, S_COMMIT, S_PAUSE
  } state_t;

  logic [4:0]    w_raw;
  logic [4:0]    r_sync1;
  logic [4:0]    r_sync2;
  logic [4:0]    r_level;
  logic [4:0]    r_pulse;
  logic [DW-1:0] r_db_cnt [5];

  logic w_p0, w_p1, w_pstart, w_ppause, w_pclear;

  state_t        r_st, w_st_nxt;
  logic [1:0]    r_state_code, w_state_code_nxt;
  logic          r_prog0, w_prog0_nxt;
  logic          r_prog1, w_prog1_nxt;
  logic          r_commit, w_commit_nxt;
  logic          r_stop, w_stop_nxt;
  logic [CW-1:0] r_cell_cnt, w_cell_cnt_nxt;
  logic [15:0]   r_gen_count, w_gen_count_nxt;
  logic          r_paused, w_paused_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          r_step, w_step_nxt;

  assign w_raw = {btn_clear_raw, btn_pause_raw, btn_start_raw, btn1_raw, btn0_raw};

  // Level flips only after DEBOUNCE_CYCLES consecutive samples disagreeing with it;
  // the pulse fires on the same edge a rising flip is accepted.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      r_pulse <= '0;
      for (int i = 0; i < 5; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 5; i++) begin
        r_pulse[i] <= 1'b0;
        if (r_sync2[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_cnt[i] <= '0;
          r_level[i]  <= r_sync2[i];
          r_pulse[i]  <= r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_p0     = r_pulse[0];
  assign w_p1     = r_pulse[1];
  assign w_pstart = r_pulse[2];
  assign w_ppause = r_pulse[3];
  assign w_pclear = r_pulse[4];

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_st         <= S_IDLE;
      r_state_code <= 2'b00;
      r_prog0      <= 1'b0;
      r_prog1      <= 1'b0;
      r_commit     <= 1'b0;
      r_stop       <= 1'b0;
      r_cell_cnt   <= '0;
      r_gen_count  <= '0;
      r_paused     <= 1'b0;
      r_timer      <= '0;
      r_step       <= 1'b0;
    end else begin
      r_st         <= w_st_nxt;
      r_state_code <= w_state_code_nxt;
      r_prog0      <= w_prog0_nxt;
      r_prog1      <= w_prog1_nxt;
      r_commit     <= w_commit_nxt;
      r_stop       <= w_stop_nxt;
      r_cell_cnt   <= w_cell_cnt_nxt;
      r_gen_count  <= w_gen_count_nxt;
      r_paused     <= w_paused_nxt;
      r_timer      <= w_timer_nxt;
      r_step       <= w_step_nxt;
    end
  end

  always_comb begin
    w_st_nxt        = r_st;
    w_prog0_nxt     = 1'b0;
    w_prog1_nxt     = 1'b0;
    // every program strobe is followed by its grid-update strobe
    w_commit_nxt    = r_prog0 | r_prog1;
    w_stop_nxt      = 1'b0;
    w_cell_cnt_nxt  = r_cell_cnt;
    w_gen_count_nxt = r_gen_count;
    w_timer_nxt     = r_timer;
    w_step_nxt      = r_step;

    if (w_pclear) begin
      w_st_nxt        = S_IDLE;
      w_stop_nxt      = 1'b1;
      w_commit_nxt    = 1'b0;
      w_cell_cnt_nxt  = '0;
      w_gen_count_nxt = '0;
      w_timer_nxt     = '0;
      w_step_nxt      = 1'b0;
    end else begin
      case (r_st)
        S_IDLE: begin
          if (w_pstart) begin
            w_st_nxt       = S_PROG;
            w_cell_cnt_nxt = '0;
          end
        end
        S_PROG: begin
          if (w_pstart) begin
            w_st_nxt    = S_WAIT;
            w_timer_nxt = '0;
          end else if (r_commit && (r_cell_cnt == CELLS_MAX)) begin
            w_st_nxt    = S_WAIT;
            w_timer_nxt = '0;
          end else if ((w_p0 ^ w_p1) && (r_cell_cnt != CELLS_MAX)) begin
            w_prog0_nxt    = w_p0;
            w_prog1_nxt    = w_p1;
            w_cell_cnt_nxt = r_cell_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (w_ppause) begin
            w_st_nxt    = S_PAUSE;
            w_timer_nxt = '0;
          end else if (r_timer == T_LAST) begin
            w_st_nxt    = S_EVAL;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
        S_EVAL: begin
          w_st_nxt        = S_COMMIT;
          w_commit_nxt    = 1'b1;
          w_gen_count_nxt = r_gen_count + 16'd1;
        end
        S_COMMIT: begin
          if (r_step) begin
            w_st_nxt   = S_PAUSE;
            w_step_nxt = 1'b0;
          end else begin
            w_st_nxt    = S_WAIT;
            w_timer_nxt = '0;
          end
        end
        S_PAUSE: begin
          if (w_ppause) begin
            w_st_nxt    = S_WAIT;
            w_timer_nxt = '0;
          end else if (w_pstart) begin
            w_st_nxt   = S_EVAL;
            w_step_nxt = 1'b1;
          end
        end
        default: w_st_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_state_code_nxt = 2'b11;
    case (w_st_nxt)
      S_IDLE:  w_state_code_nxt = 2'b00;
      S_PROG:  w_state_code_nxt = 2'b01;
      S_EVAL:  w_state_code_nxt = 2'b10;
      default: w_state_code_nxt = 2'b11;
    endcase
  end

  assign w_paused_nxt = (w_st_nxt == S_PAUSE) || w_step_nxt;

  assign state     = r_state_code;
  assign prog0     = r_prog0;
  assign prog1     = r_prog1;
  assign commit    = r_commit;
  assign stop      = r_stop;
  assign cell_cnt  = r_cell_cnt;
  assign gen_count = r_gen_count;
  assign paused    = r_paused;

endmodule

// File: tb/tb_life_controller.sv
// tb/tb_life_controller.sv - directed bench for life_controller
// Small parameters (debounce 4, period 8); expected values are hand-derived cycle counts.
module tb_life_controller;

  localparam int NC = 49;
  localparam int CW = $clog2(NC + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          b0 = 1'b0, b1 = 1'b0, bs = 1'b0, bp = 1'b0, bc = 1'b0;
  logic [1:0]    state;
  logic          prog0, prog1, commit, stop, paused;
  logic [CW-1:0] cell_cnt;
  logic [15:0]   gen_count;

  int n_total = 0, n_bad = 0;
  int n_p0 = 0, n_p1 = 0, n_commit = 0, n_stop = 0, n_eval = 0;
  int n_overlap = 0, n_both = 0, n_unpaused = 0;

  life_controller #(.NUM_CELLS(NC), .DEBOUNCE_CYCLES(4), .GEN_PERIOD(8)) dut (
    .clka(clk), .rst(rst),
    .btn0_raw(b0), .btn1_raw(b1), .btn_start_raw(bs), .btn_pause_raw(bp), .btn_clear_raw(bc),
    .state(state), .prog0(prog0), .prog1(prog1), .commit(commit), .stop(stop),
    .cell_cnt(cell_cnt), .gen_count(gen_count), .paused(paused)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (prog0) n_p0++;
    if (prog1) n_p1++;
    if (commit) n_commit++;
    if (stop) n_stop++;
    if (state == 2'b10) n_eval++;
    if (commit && state == 2'b10) n_overlap++;
    if (prog0 && prog1) n_both++;
    if (!paused) n_unpaused++;
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: b0 = v;
      1: b1 = v;
      2: bs = v;
      3: bp = v;
      default: bc = v;
    endcase
  endtask

  task automatic press(input int idx);
    set_btn(idx, 1'b1);
    repeat (8) tick();
    set_btn(idx, 1'b0);
    repeat (8) tick();
  endtask

  int lat, t, k, s8, s18, snap, snap2;
  int ev[3];

  initial begin
    repeat (2) tick();
    check("rst_state", state, 0);
    check("rst_prog0", prog0, 0);
    check("rst_prog1", prog1, 0);
    check("rst_commit", commit, 0);
    check("rst_stop", stop, 0);
    check("rst_cell_cnt", cell_cnt, 0);
    check("rst_gen_count", gen_count, 0);
    check("rst_paused", paused, 0);
    rst = 1'b0;
    repeat (2) tick();

    press(2);
    check("idle_to_prog", state, 1);

    // 3-cycle glitch must not survive the debouncer
    b1 = 1'b1;
    repeat (3) tick();
    b1 = 1'b0;
    repeat (10) tick();
    check("glitch_no_prog1", n_p1, 0);
    check("glitch_cell_cnt", cell_cnt, 0);

    lat = 0;
    b1 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (prog1 && lat == 0) lat = i;
      if (i == 10) b1 = 1'b0;
    end
    repeat (8) tick();
    check("prog1_latency", lat, 7);
    check("prog1_once", n_p1, 1);
    check("prog1_commit", n_commit, 1);
    check("prog1_cell_cnt", cell_cnt, 1);

    for (int i = 0; i < 47; i++) press(i % 2);
    b1 = 1'b1;
    for (int i = 0; i < 20 && n_commit < 49; i++) tick();
    check("prog_commits", n_commit, 49);
    tick();
    check("auto_wait_state", state, 3);
    b1 = 1'b0;
    check("prog0_strobes", n_p0, 24);
    check("prog1_strobes", n_p1, 25);
    check("full_cell_cnt", cell_cnt, 49);

    t = 0; k = 0;
    ev[0] = 0; ev[1] = 0; ev[2] = 0;
    while (k < 3 && t < 60) begin
      tick();
      t++;
      if (state == 2'b10) begin
        ev[k] = t;
        k++;
      end
    end
    tick();
    check("eval1_time", ev[0], 8);
    check("eval2_time", ev[1], 18);
    check("eval3_time", ev[2], 28);
    check("gen_commit_follows", commit, 1);
    check("gen_count3", gen_count, 3);

    // pause pulse lands at WAIT timer 5
    bp = 1'b1;
    repeat (8) tick();
    bp = 1'b0;
    repeat (8) tick();
    check("pause_state", state, 3);
    check("pause_paused", paused, 1);
    snap = n_eval;
    repeat (20) tick();
    check("pause_no_eval", n_eval - snap, 0);
    check("pause_gen", gen_count, 3);

    n_unpaused = 0;
    snap = n_eval;
    snap2 = n_commit;
    press(2);
    press(2);
    check("step_evals", n_eval - snap, 2);
    check("step_commits", n_commit - snap2, 2);
    check("step_gen", gen_count, 5);
    check("step_paused_held", n_unpaused, 0);
    check("step_state", state, 3);

    bp = 1'b1;
    for (int i = 0; i < 20 && paused; i++) tick();
    bp = 1'b0;
    check("resume_unpaused", paused, 0);
    snap = n_eval;
    s8 = 0; s18 = 0;
    for (t = 1; t <= 40; t++) begin
      tick();
      if (t == 8) s8 = state;
      if (t == 18) s18 = state;
      if (t == 11) bp = 1'b1;
      if (t == 19) bp = 1'b0;
    end
    check("resume_eval_t8", s8, 2);
    check("term_pause_no_eval", s18, 3);
    check("term_pause_evals", n_eval - snap, 1);
    check("term_pause_paused", paused, 1);

    snap = n_stop;
    snap2 = n_eval;
    bc = 1'b1;
    bs = 1'b1;
    repeat (8) tick();
    bc = 1'b0;
    bs = 1'b0;
    repeat (8) tick();
    check("clear_stop_once", n_stop - snap, 1);
    check("clear_state", state, 0);
    check("clear_gen", gen_count, 0);
    check("clear_cell_cnt", cell_cnt, 0);
    check("clear_paused", paused, 0);
    check("clear_no_step", n_eval - snap2, 0);

    press(2);
    press(2);
    check("start_skip_wait", state, 3);
    for (int i = 0; i < 40 && state != 2'b10; i++) tick();
    check("reached_eval", state, 2);
    rst = 1'b1;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_commit", commit, 0);
    check("async_rst_stop", stop, 0);
    snap = n_commit;
    snap2 = n_stop;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rst_no_commit", n_commit - snap, 0);
    check("rst_no_stop", n_stop - snap2, 0);
    press(2);
    check("post_rst_prog", state, 1);

    check("commit_eval_overlap", n_overlap, 0);
    check("prog_both", n_both, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/life_controller.md
# life_controller

Sequencing controller for the 7x7 Game of Life datapath. It debounces the raw board buttons and drives the datapath's 2-bit `state` code and cell-program strobes. It schedules each generation as a one-cycle evaluate followed by a one-cycle commit at a fixed period, and supports pause, single-step and clear. It runs on the datapath clock domain; `commit` is the enable for the datapath's grid-update clock.

## Interface
- `NUM_CELLS`, 49: cells programmed before auto-start; `CW = $clog2(NUM_CELLS+1)` (6 by default).
- `DEBOUNCE_CYCLES`, 250000: consecutive stable synchronized samples needed to change a debounced level (>=1).
- `GEN_PERIOD`, 25000000: WAIT cycles per generation (>=1).

- `clka`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `btn0_raw`, `btn1_raw`, `btn_start_raw`, `btn_pause_raw`, `btn_clear_raw`  in  1 each  raw push buttons, asynchronous.
- `state`  out  2  datapath mode: 00 IDLE, 01 PROGRAM, 10 RUN/evaluate, 11 hold.
- `prog0`, `prog1`  out  1 each  single-cycle write-0 / write-1 strobes to the datapath.
- `commit`  out  1  single-cycle grid-update strobe.
- `stop`  out  1  single-cycle grid-clear strobe.
- `cell_cnt`  out  CW  cells programmed so far.
- `gen_count`  out  16  generations committed since last clear; wraps 0xFFFF->0.
- `paused`  out  1  high in S_PAUSE and during a single step.

## Operation
- Button front end, per button:
  - 2-FF synchronizer feeds a stable-counter debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples that differ from the current level.
  - A debounced rising edge gives a 1-cycle internal pulse: `p0`, `p1`, `pstart`, `ppause`, `pclear`.
- FSM states and `state` encoding:
  - S_IDLE -> 00, S_PROG -> 01, S_EVAL -> 10.
  - S_WAIT, S_COMMIT, S_PAUSE -> 11.
- S_IDLE: `pstart` -> S_PROG, `cell_cnt` <= 0.
- S_PROG:
  - `p0` xor `p1` -> matching `prog0`/`prog1` the next cycle, `cell_cnt` +1, `commit` the cycle after that.
  - `p0` and `p1` in the same cycle -> both ignored, no strobe, no count.
  - `cell_cnt` reaching NUM_CELLS -> S_WAIT the cycle after that write's `commit`.
  - `pstart` -> S_WAIT immediately; the unprogrammed remainder stays 0.
- S_WAIT:
  - Timer counts 0..GEN_PERIOD-1; at GEN_PERIOD-1 -> S_EVAL.
  - `ppause` -> S_PAUSE; the timer is discarded.
- S_EVAL: exactly one cycle -> S_COMMIT.
- S_COMMIT: `commit`=1 for one cycle, `gen_count` +1, then:
  - S_PAUSE if the step flag is set (flag cleared);
  - S_WAIT otherwise, with the timer reset to 0.
- S_PAUSE:
  - `ppause` -> S_WAIT with the timer reset to 0.
  - `pstart` -> sets the step flag -> S_EVAL; one generation, then back to S_PAUSE.
- `pclear` in any state:
  - `stop`=1 for one cycle; `gen_count`, `cell_cnt`, timer and step flag <= 0; -> S_IDLE.
  - Has priority over every other event in the same cycle.
- Priority in S_WAIT: `pclear` > `ppause` > timer terminal. Pause on the terminal cycle means no EVAL.
- `pstart` in S_WAIT/S_EVAL/S_COMMIT and `p0`/`p1` outside S_PROG are ignored.

## Timing
- All outputs are registered.
- Reset values: `state`=00, `prog0`=`prog1`=`commit`=`stop`=0, `cell_cnt`=0, `gen_count`=0, `paused`=0. All debounced levels are 0; timer and step flag are 0.
- Raw button rising at cycle t and held: internal pulse at t+2+DEBOUNCE_CYCLES (2 sync + count); output strobe one cycle later.
- Running generation period = GEN_PERIOD+2 cycles (WAIT + EVAL + COMMIT).
  - `state`=10 for exactly one cycle, immediately followed by `commit`=1.
- `commit` never coincides with `state`=10. `prog0`/`prog1`/`commit`/`stop` are each at most one cycle wide.
- Reset mid-generation (including in S_EVAL): outputs return to reset values asynchronously; no `commit` or `stop` is issued.
- Holding a button does not repeat; re-arm requires a debounced release.

## Test plan
- DEBOUNCE_CYCLES=4: `btn1_raw` high for 3 cycles then low -> no `prog1`. Held for 10 cycles in S_PROG -> exactly one `prog1`, 7 cycles after the rise; `cell_cnt`=1.
- NUM_CELLS=49: 49 alternating `btn0`/`btn1` presses -> 49 strobes and 49 commits, `cell_cnt`=49, then auto S_WAIT (`state`=11).
- GEN_PERIOD=8 in S_WAIT: `state`=10 every 10 cycles, `commit` the next cycle; after 3 periods `gen_count`=3.
- Pause, then two `pstart` presses -> exactly two EVAL/COMMIT pairs; `gen_count` +2; `paused` stays 1; FSM stays in S_PAUSE.
- `ppause` and timer terminal in the same cycle -> S_PAUSE, no `state`=10. `pclear` together with `pstart` -> `stop` pulse, S_IDLE, counters 0.
- Assert `rst` during S_EVAL -> `state`=00 and all strobes 0 within the same cycle. After release, `pstart` -> S_PROG.
